// File: rtl/adc_sample_store_mc.sv
// adc_sample_store_mc
//   Captures tagged ADC sequencer samples into a small slot store and exposes
//   them on an Avalon-MM style CSR port. Two capture modes:
//     SNAPSHOT : each sequence (SOP..EOP) is laid out from slot 0 upward.
//     FIFO     : ring buffer with a programmable watermark and a pop port.
//   Optional feature macro: ADC_SAMPLE_STORE_TIMESTAMP_EN (cycle-counter
//   timestamp latched on every SEQ_DONE set event, readable at 0x44).
//
// Ports
//   clock_clk, reset_sink_reset_n      clock, asynchronous active-low reset
//   response_valid/channel/data        sample beat (always accepted)
//   response_startofpacket/endofpacket sequence framing
//   csr_address/read/write/writedata   CSR access, word addressed
//   csr_readdata                       registered read data (1-cycle latency)
//   irq                                registered level interrupt
//
// Stream handshake: the response stream has no ready; a beat is consumed on
// every cycle response_valid is high. The CSR port has no waitrequest; a read
// strobe returns data on csr_readdata the next cycle and it holds until the
// next read strobe.

module adc_sample_store_mc #(
  parameter int DATA_W    = 12,
  parameter int CH_W      = 5,
  parameter int NUM_SLOTS = 64,
  parameter int RST_WM    = 32
) (
  input  logic              clock_clk,
  input  logic              reset_sink_reset_n,
  input  logic              response_valid,
  input  logic [CH_W-1:0]   response_channel,
  input  logic [DATA_W-1:0] response_data,
  input  logic              response_startofpacket,
  input  logic              response_endofpacket,
  input  logic [6:0]        csr_address,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  output logic              irq
);

  localparam int AW = $clog2(NUM_SLOTS);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(NUM_SLOTS);

  localparam logic [6:0] A_CTRL   = 7'h40;
  localparam logic [6:0] A_STATUS = 7'h41;
  localparam logic [6:0] A_WM     = 7'h42;
  localparam logic [6:0] A_POP    = 7'h43;
  localparam logic [6:0] A_TS     = 7'h44;

  logic                     irq_en, mode, seq_done, overflow, drop_latch;
  logic [7:0]               wm;
  logic [CW-1:0]            wr_idx, fcount, count;
  logic [AW-1:0]            rd_ptr, push_idx, snap_idx, wr_addr;
  logic [NUM_SLOTS-1:0]     vld, vld_n;
  logic [DATA_W+CH_W-1:0]   mem [NUM_SLOTS];

  logic ctrl_wr, status_wr, clear, wm_hit, full, pop, pop_do;
  logic beat, snap_beat, snap_drop, snap_store;
  logic fifo_beat, fifo_store, fifo_drop, wr_en, seq_set, ovf_set;
  logic [31:0] rd_next;
  logic unused_wdata;

  assign unused_wdata = ^csr_writedata[31:8];

  function automatic logic [31:0] fmt(input logic [DATA_W+CH_W-1:0] e);
    fmt              = '0;
    fmt[DATA_W-1:0]  = e[DATA_W-1:0];
    fmt[16 +: CH_W]  = e[DATA_W +: CH_W];
    fmt[31]          = 1'b1;
  endfunction

  // A mode change restarts capture from an empty store.
  assign ctrl_wr   = csr_write && (csr_address == A_CTRL);
  assign status_wr = csr_write && (csr_address == A_STATUS);
  assign clear     = ctrl_wr && (csr_writedata[2] || (csr_writedata[1] != mode));

  assign count  = mode ? fcount : wr_idx;
  assign wm_hit = (8'(count) >= wm) && (wm != 8'd0);
  assign full   = (fcount == FULL_CNT);

  // pop drives the returned data; pop_do is the state side effect.
  assign pop    = csr_read && (csr_address == A_POP) && mode && (fcount != '0);
  assign pop_do = pop && !clear;

  assign beat       = response_valid && !clear;
  assign snap_beat  = beat && !mode;
  assign snap_drop  = snap_beat && !response_startofpacket &&
                      (drop_latch || (wr_idx == FULL_CNT));
  assign snap_store = snap_beat && !snap_drop;
  assign snap_idx   = response_startofpacket ? '0 : wr_idx[AW-1:0];

  // When full, push_idx equals rd_ptr: a simultaneous pop frees that slot.
  assign fifo_beat  = beat && mode;
  assign push_idx   = rd_ptr + fcount[AW-1:0];
  assign fifo_store = fifo_beat && (!full || pop_do);
  assign fifo_drop  = fifo_beat && full && !pop_do;

  assign wr_en   = snap_store || fifo_store;
  assign wr_addr = mode ? push_idx : snap_idx;
  assign seq_set = response_endofpacket && (snap_store || fifo_beat);
  assign ovf_set = snap_drop || fifo_drop;

  // Pop clears the head slot; a same-cycle push into that slot wins.
  always_comb begin
    vld_n = vld;
    if (pop_do) vld_n[rd_ptr]  = 1'b0;
    if (wr_en)  vld_n[wr_addr] = 1'b1;
  end

`ifdef ADC_SAMPLE_STORE_TIMESTAMP_EN
  logic [31:0] ts_cnt, ts_cap;
  always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
    if (!reset_sink_reset_n) begin
      ts_cnt <= '0;
      ts_cap <= '0;
    end else begin
      ts_cnt <= ts_cnt + 32'd1;
      if (clear)        ts_cap <= '0;
      else if (seq_set) ts_cap <= ts_cnt;
    end
  end
`endif

  always_comb begin
    rd_next = '0;
    if (csr_address < 7'(NUM_SLOTS)) begin
      if (vld[csr_address[AW-1:0]]) rd_next = fmt(mem[csr_address[AW-1:0]]);
    end else begin
      case (csr_address)
        A_CTRL:   rd_next = {30'd0, mode, irq_en};
        A_STATUS: rd_next = {8'd0, 8'(count), 13'd0, wm_hit, overflow, seq_done};
        A_WM:     rd_next = {24'd0, wm};
        A_POP:    rd_next = pop ? fmt(mem[rd_ptr]) : 32'd0;
`ifdef ADC_SAMPLE_STORE_TIMESTAMP_EN
        A_TS:     rd_next = ts_cap;
`else
        A_TS:     rd_next = 32'd0;
`endif
        default:  rd_next = 32'd0;
      endcase
    end
  end

  // Slot payload carries no reset; the valid bits gate what is visible.
  always_ff @(posedge clock_clk) begin
    if (wr_en) mem[wr_addr] <= {response_channel, response_data};
  end

  always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
    if (!reset_sink_reset_n) begin
      csr_readdata <= '0;
      irq          <= 1'b0;
      irq_en       <= 1'b0;
      mode         <= 1'b0;
      wm           <= 8'(RST_WM);
      seq_done     <= 1'b0;
      overflow     <= 1'b0;
      drop_latch   <= 1'b0;
      wr_idx       <= '0;
      fcount       <= '0;
      rd_ptr       <= '0;
      vld          <= '0;
    end else begin
      if (csr_read) csr_readdata <= rd_next;
      irq <= irq_en & (seq_done | overflow | (mode & wm_hit));

      if (ctrl_wr) begin
        irq_en <= csr_writedata[0];
        mode   <= csr_writedata[1];
      end
      if (csr_write && (csr_address == A_WM)) wm <= csr_writedata[7:0];

      if (clear) begin
        seq_done   <= 1'b0;
        overflow   <= 1'b0;
        drop_latch <= 1'b0;
        wr_idx     <= '0;
        fcount     <= '0;
        rd_ptr     <= '0;
        vld        <= '0;
      end else begin
        // Flag set has priority over a same-cycle write-1-to-clear.
        if (seq_set)                              seq_done <= 1'b1;
        else if (status_wr && csr_writedata[0])   seq_done <= 1'b0;
        if (ovf_set)                              overflow <= 1'b1;
        else if (status_wr && csr_writedata[1])   overflow <= 1'b0;

        if (snap_beat && response_startofpacket) drop_latch <= 1'b0;
        else if (snap_drop)                      drop_latch <= 1'b1;

        if (snap_store)
          wr_idx <= response_startofpacket ? CW'(1) : wr_idx + CW'(1);

        if (pop_do) rd_ptr <= rd_ptr + AW'(1);
        case ({fifo_store, pop_do})
          2'b10:   fcount <= fcount + CW'(1);
          2'b01:   fcount <= fcount - CW'(1);
          default: fcount <= fcount;
        endcase

        vld <= vld_n;
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_store_mc.sv
// Testbench for adc_sample_store_mc: randomized beats and CSR traffic checked
// against a queue/array reference model. readdata and irq are compared on
// every cycle; key scenarios also get literal checks.
module tb_adc_sample_store_mc;
  localparam int DATA_W = 12;
  localparam int CH_W   = 5;
  localparam int N      = 64;
  localparam int RST_WM = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              response_valid;
  logic [CH_W-1:0]   response_channel;
  logic [DATA_W-1:0] response_data;
  logic              response_startofpacket, response_endofpacket;
  logic [6:0]        csr_address;
  logic              csr_read, csr_write;
  logic [31:0]       csr_writedata, csr_readdata;
  logic              irq;

  int n_checks = 0;
  int n_fail   = 0;

  adc_sample_store_mc #(.DATA_W(DATA_W), .CH_W(CH_W), .NUM_SLOTS(N), .RST_WM(RST_WM)) dut (
    .clock_clk(clk), .reset_sink_reset_n(rst_n),
    .response_valid(response_valid), .response_channel(response_channel),
    .response_data(response_data), .response_startofpacket(response_startofpacket),
    .response_endofpacket(response_endofpacket), .csr_address(csr_address),
    .csr_read(csr_read), .csr_write(csr_write), .csr_writedata(csr_writedata),
    .csr_readdata(csr_readdata), .irq(irq)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no end of test, expected finish");
    $fatal(1, "timeout");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_slots [N];
  logic [31:0] exp_q [$];
  int          m_head, m_wr_idx;
  bit          m_mode, m_irq_en, m_sd, m_ovf, m_dropping, m_irq;
  logic [7:0]  m_wm;
  logic [31:0] m_rdata, m_ts, m_cyc;

  function automatic int m_count();
    return m_mode ? exp_q.size() : m_wr_idx;
  endfunction

  function automatic bit m_wm_hit();
    return (m_count() >= int'(m_wm)) && (m_wm != 8'd0);
  endfunction

  function automatic logic [31:0] mk(input logic [7:0] ch, input logic [15:0] d);
    logic [31:0] e;
    e = 32'h8000_0000;
    e[16 +: CH_W] = ch[CH_W-1:0];
    e[DATA_W-1:0] = d[DATA_W-1:0];
    return e;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_slots[i] = '0;
    exp_q.delete();
    m_head = 0; m_wr_idx = 0; m_sd = 0; m_ovf = 0; m_dropping = 0; m_ts = '0;
  endtask

  task automatic model_reset();
    model_clear();
    m_mode = 0; m_irq_en = 0; m_irq = 0; m_wm = 8'(RST_WM); m_rdata = '0; m_cyc = '0;
  endtask

  function automatic logic [31:0] exp_read(input logic [6:0] a);
    logic [31:0] r;
    r = '0;
    if (int'(a) < N) r = m_slots[a];
    else case (a)
      7'h40: r = {30'd0, m_mode, m_irq_en};
      7'h41: r = {8'd0, 8'(m_count()), 13'd0, m_wm_hit(), m_ovf, m_sd};
      7'h42: r = {24'd0, m_wm};
      7'h43: r = (m_mode && exp_q.size() > 0) ? exp_q[0] : 32'd0;
`ifdef ADC_SAMPLE_STORE_TIMESTAMP_EN
      7'h44: r = m_ts;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  // ---------------- driver ----------------
  // One clock cycle of stimulus; starts and ends at a falling edge.
  task automatic cycle(input bit v, input logic [7:0] ch, input logic [15:0] d,
                       input bit sop, input bit eop, input bit rd, input bit wr,
                       input logic [6:0] a, input logic [31:0] wd);
    bit clr, pop, sd_set, ov_set, irq_next, full;
    int push_slot;
    logic [31:0] e;
    response_valid = v; response_channel = ch[CH_W-1:0]; response_data = d[DATA_W-1:0];
    response_startofpacket = sop; response_endofpacket = eop;
    csr_read = rd; csr_write = wr; csr_address = a; csr_writedata = wd;

    irq_next = m_irq_en & (m_sd | m_ovf | (m_mode & m_wm_hit()));
    if (rd) m_rdata = exp_read(a);
    clr = wr && a == 7'h40 && (wd[2] || wd[1] != m_mode);
    pop = rd && a == 7'h43 && m_mode && exp_q.size() > 0 && !clr;
    sd_set = 0; ov_set = 0; e = mk(ch, d);
    if (clr) model_clear();
    if (wr && a == 7'h40) begin m_irq_en = wd[0]; m_mode = wd[1]; end
    if (wr && a == 7'h42) m_wm = wd[7:0];
    if (wr && a == 7'h41) begin
      if (wd[0]) m_sd = 0;
      if (wd[1]) m_ovf = 0;
    end
    if (!clr && m_mode) begin
      push_slot = (m_head + exp_q.size()) % N;
      full = exp_q.size() == N;
      if (pop) begin
        void'(exp_q.pop_front());
        m_slots[m_head] = '0;
        m_head = (m_head + 1) % N;
      end
      if (v) begin
        if (full && !pop) ov_set = 1;
        else begin m_slots[push_slot] = e; exp_q.push_back(e); end
        if (eop) sd_set = 1;
      end
    end else if (!clr && v) begin
      if (sop) begin
        m_slots[0] = e; m_wr_idx = 1; m_dropping = 0; sd_set = eop;
      end else if (m_dropping || m_wr_idx == N) begin
        ov_set = 1; m_dropping = 1;
      end else begin
        m_slots[m_wr_idx] = e; m_wr_idx++; sd_set = eop;
      end
    end
    if (sd_set) begin m_sd = 1; m_ts = m_cyc; end
    if (ov_set) m_ovf = 1;
    m_cyc++;

    @(negedge clk);
    response_valid = 0; csr_read = 0; csr_write = 0;
    m_irq = irq_next;
    check("readdata", csr_readdata, m_rdata);
    check("irq", {31'd0, irq}, {31'd0, m_irq});
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic beat(input logic [7:0] ch, input logic [15:0] d, input bit sop, input bit eop);
    cycle(1, ch, d, sop, eop, 0, 0, 0, 0);
  endtask

  task automatic rd(input logic [6:0] a, output logic [31:0] dat);
    cycle(0, 0, 0, 0, 0, 1, 0, a, 0);
    dat = csr_readdata;
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] wd);
    cycle(0, 0, 0, 0, 0, 0, 1, a, wd);
  endtask

  task automatic rand_beat(input bit sop, input bit eop);
    beat(8'($urandom_range(0, 31)), 16'($urandom_range(0, 4095)), sop, eop);
  endtask

  task automatic read_all_slots();
    logic [31:0] dat;
    for (int i = 0; i < N; i++) rd(7'(i), dat);
  endtask

  task automatic do_reset();
    rst_n = 0;
    response_valid = 0; csr_read = 0; csr_write = 0;
    response_channel = '0; response_data = '0;
    response_startofpacket = 0; response_endofpacket = 0;
    csr_address = '0; csr_writedata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_readdata", csr_readdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    rst_n = 1;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] dat;
  int len;

  initial begin
    rst_n = 0;
    @(negedge clk);
    do_reset();

    // Reset register values.
    rd(7'h40, dat); check("rst_ctrl", dat, 32'd0);
    rd(7'h41, dat); check("rst_status", dat, 32'd0);
    rd(7'h42, dat); check("rst_wm", dat, 32'(RST_WM));
    rd(7'h00, dat); rd(7'h43, dat); rd(7'h44, dat); rd(7'h7f, dat);

    // Snapshot 4-beat sequence with interrupt enabled.
    wr(7'h40, 32'd1);
    for (int i = 0; i < 4; i++) beat(8'(i), 16'(16'h100 + i), i == 0, i == 3);
    idle(1);
    rd(7'h02, dat); check("snap_slot2", dat, 32'h8002_0102);
    rd(7'h41, dat); check("snap_status", dat, 32'h0004_0001);
    check("snap_irq", {31'd0, irq}, 32'd1);
    wr(7'h41, 32'd1);
    idle(2);
    check("w1c_irq_low", {31'd0, irq}, 32'd0);

    // Random snapshot sequences, some long enough to overflow.
    for (int s = 0; s < 4; s++) begin
      len = $urandom_range(1, 70);
      for (int i = 0; i < len; i++) begin
        rand_beat(i == 0, i == len - 1);
        if ($urandom_range(0, 3) == 0) idle(1);
      end
      read_all_slots();
      rd(7'h41, dat);
      wr(7'h41, 32'd3);
    end

    // 66-beat sequence: 64 stored, then overflow and drops.
    for (int i = 0; i < 66; i++) rand_beat(i == 0, 0);
    rd(7'h41, dat); check("ovf_count", {24'd0, dat[23:16]}, 32'd64);
    check("ovf_flag", {31'd0, dat[1]}, 32'd1);
    // W1C racing a drop: the set wins.
    cycle(1, 8'd7, 16'h7, 0, 0, 0, 1, 7'h41, 32'd2);
    read_all_slots();
    rand_beat(1, 0);
    rd(7'h00, dat);
    rd(7'h41, dat); check("sop_restart_count", {24'd0, dat[23:16]}, 32'd1);

    // FIFO with watermark 3.
    wr(7'h40, 32'd3);
    wr(7'h42, 32'd3);
    for (int i = 0; i < 3; i++) rand_beat(0, 0);
    idle(1);
    rd(7'h41, dat); check("fifo_wm_hit", {31'd0, dat[2]}, 32'd1);
    check("fifo_wm_irq", {31'd0, irq}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      rd(7'h43, dat); check("fifo_pop_valid", {31'd0, dat[31]}, 32'd1);
    end
    rd(7'h43, dat); check("fifo_pop_empty", dat, 32'd0);
    rd(7'h41, dat); check("fifo_wm_clear", {31'd0, dat[2]}, 32'd0);

    // Full FIFO: push and pop together, then push alone.
    for (int i = 0; i < N; i++) rand_beat(0, 0);
    cycle(1, 8'd9, 16'h99, 0, 0, 1, 0, 7'h43, 0);
    rd(7'h41, dat);
    check("full_pp_count", {24'd0, dat[23:16]}, 32'd64);
    check("full_pp_ovf", {31'd0, dat[1]}, 32'd0);
    rand_beat(0, 0);
    rd(7'h41, dat); check("full_push_ovf", {31'd0, dat[1]}, 32'd1);
    read_all_slots();

    // Random FIFO traffic with CLEAR pulse, random watermark and W1C writes.
    wr(7'h40, 32'd7);
    wr(7'h42, 32'($urandom_range(1, 64)));
    for (int i = 0; i < 500; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: cycle(1, 8'($urandom), 16'($urandom), bit'($urandom), bit'($urandom), 0, 0, 0, 0);
        3, 4:    cycle(0, 0, 0, 0, 0, 1, 0, 7'h43, 0);
        5:       cycle(1, 8'($urandom), 16'($urandom), 0, 0, 1, 0, 7'h43, 0);
        6:       cycle(0, 0, 0, 0, 0, 1, 0, 7'($urandom_range(0, 127)), 0);
        7:       cycle(1, 8'($urandom), 16'($urandom), 0, 0, 0, 1, 7'h41, 32'($urandom_range(0, 3)));
        default: idle(1);
      endcase
    end
    read_all_slots();

    // Mode change with a same-cycle beat: store cleared, beat dropped.
    cycle(1, 8'd3, 16'h333, 1, 1, 0, 1, 7'h40, 32'd0);
    idle(1);
    read_all_slots();
    rd(7'h41, dat); check("toggle_status", dat, 32'd0);
    check("toggle_irq", {31'd0, irq}, 32'd0);

    // Timestamp: SOP+EOP single-beat sequence.
    beat(8'd1, 16'h55, 1, 1);
    idle(1);
    rd(7'h44, dat);
`ifndef ADC_SAMPLE_STORE_TIMESTAMP_EN
    check("ts_absent", dat, 32'd0);
`endif

    // Reset mid-sequence.
    wr(7'h40, 32'd1);
    for (int i = 0; i < 5; i++) rand_beat(i == 0, 0);
    #2 rst_n = 0;
    model_reset();
    @(negedge clk);
    check("midrst_readdata", csr_readdata, 32'd0);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    read_all_slots();
    rd(7'h41, dat); check("midrst_status", dat, 32'd0);
    rd(7'h40, dat); check("midrst_ctrl", dat, 32'd0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
